// File: rtl/dec_lock_ctrl.sv
// Word-lock hunt controller: slips the gearbox until the FEC CRC comparator locks.
// Define DEC_LOCK_STATS_EN to build the LOSS/BLK/ERR statistics counters and STAT_CLR.
module dec_lock_ctrl #(
  parameter int MAX_SLIP = 66,
  parameter int ACK_TO   = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_ENA,
  input  logic [3:0]       CFG_SETTLE,
  input  logic             BLK_DONE,
  input  logic             CRC_FAIL,
  input  logic             FEC_LOCK,
  input  logic             SLIP_ACK,
  input  logic             STAT_CLR,
  output logic             SLIP_REQ,
  output logic             LOCKED,
  output logic             HUNT_TMO,
  output logic             ACK_ERR,
  output logic [6:0]       SLIP_CNT,
  output logic [CNT_W-1:0] LOSS_CNT,
  output logic [CNT_W-1:0] BLK_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int TMR_W = $clog2(ACK_TO + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic             slip_req_q, slip_req_d;
  logic             locked_q, locked_d;
  logic             hunt_tmo_q, hunt_tmo_d;
  logic             ack_err_q, ack_err_d;
  logic [6:0]       slip_cnt_q, slip_cnt_d;
  logic [6:0]       slip_cnt_inc;
  logic [3:0]       settle_left_q, settle_left_d;
  logic [TMR_W-1:0] ack_tmr_q, ack_tmr_d;
  logic             lost_lock;

  assign slip_cnt_inc = slip_cnt_q + 7'd1;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    slip_cnt_d    = slip_cnt_q;
    settle_left_d = settle_left_q;
    ack_tmr_d     = ack_tmr_q;
    hunt_tmo_d    = 1'b0;
    ack_err_d     = 1'b0;
    lost_lock     = 1'b0;

    if (!CFG_ENA) begin
      state_d    = ST_IDLE;
      slip_cnt_d = 7'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_HUNT;

        ST_HUNT: begin
          ack_tmr_d = '0;
          if (FEC_LOCK)                  state_d = ST_LOCKED;
          else if (BLK_DONE && CRC_FAIL) state_d = ST_SLIP;
        end

        ST_SLIP: begin
          // An acknowledge on the expiry cycle is checked first, so it still counts.
          if (SLIP_ACK) begin
            state_d       = ST_SETTLE;
            settle_left_d = CFG_SETTLE;
            if (slip_cnt_inc == 7'(MAX_SLIP)) begin
              hunt_tmo_d = 1'b1;
              slip_cnt_d = 7'd0;
            end else begin
              slip_cnt_d = slip_cnt_inc;
            end
          end else if (ack_tmr_q == TMR_W'(ACK_TO - 1)) begin
            ack_err_d     = 1'b1;
            state_d       = ST_SETTLE;
            settle_left_d = CFG_SETTLE;
          end else begin
            ack_tmr_d = ack_tmr_q + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (settle_left_q == 4'd0) begin
            state_d = ST_HUNT;
          end else if (BLK_DONE) begin
            settle_left_d = settle_left_q - 4'd1;
            if (settle_left_q == 4'd1) state_d = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (!FEC_LOCK) begin
            state_d    = ST_HUNT;
            slip_cnt_d = 7'd0;
            lost_lock  = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Flag outputs are decoded from the next state so they are registered with it.
    slip_req_d = (state_d == ST_SLIP);
    locked_d   = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      slip_req_q    <= 1'b0;
      locked_q      <= 1'b0;
      hunt_tmo_q    <= 1'b0;
      ack_err_q     <= 1'b0;
      slip_cnt_q    <= 7'd0;
      settle_left_q <= 4'd0;
      ack_tmr_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= state_d;
      slip_req_q    <= slip_req_d;
      locked_q      <= locked_d;
      hunt_tmo_q    <= hunt_tmo_d;
      ack_err_q     <= ack_err_d;
      slip_cnt_q    <= slip_cnt_d;
      settle_left_q <= settle_left_d;
      ack_tmr_q     <= ack_tmr_d;
    end
  end

  assign SLIP_REQ = slip_req_q;
  assign LOCKED   = locked_q;
  assign HUNT_TMO = hunt_tmo_q;
  assign ACK_ERR  = ack_err_q;
  assign SLIP_CNT = slip_cnt_q;

`ifdef DEC_LOCK_STATS_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    err_cnt_d  = err_cnt_q;
    // Clear takes priority over any increment in the same cycle.
    if (STAT_CLR) begin
      loss_cnt_d = '0;
      blk_cnt_d  = '0;
      err_cnt_d  = '0;
    end else begin
      if (lost_lock && (loss_cnt_q != '1))                      loss_cnt_d = loss_cnt_q + 1'b1;
      if (locked_q && BLK_DONE && (blk_cnt_q != '1))            blk_cnt_d  = blk_cnt_q + 1'b1;
      if (locked_q && BLK_DONE && CRC_FAIL && (err_cnt_q != '1)) err_cnt_d  = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      loss_cnt_q <= '0;
      blk_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
  assign BLK_CNT  = blk_cnt_q;
  assign ERR_CNT  = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = STAT_CLR ^ lost_lock;

  assign LOSS_CNT = '0;
  assign BLK_CNT  = '0;
  assign ERR_CNT  = '0;
`endif

endmodule
